// File: rtl/aes_pkg.sv
// Shared types and GF(2^8) helpers for the AES-128 encryption sequencer.
package aes_pkg;

  typedef enum logic [2:0] {
    IDLE, KX_START, KX_WAIT, ROUND0, ROUNDS, FINAL, DONE, ERR
  } ctrl_state_t;

  localparam int NR_AES128 = 10;
  localparam logic [7:0] XTIME_POLY = 8'h1b;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box computed as the affine transform of the multiplicative inverse (x^254, 0 maps to 0).
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] inv;
    logic [7:0] sq;
    inv = 8'h01;
    sq  = b;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_round_fn.sv
// Combinational AES round: sub_bytes, shift_rows, optional mix_columns, add_round_key.
module aes_round_fn
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] round_key,
  input  logic         mix_en,
  output logic [127:0] result
);

  logic [127:0] sb;
  logic [127:0] sr;
  logic [127:0] mc;
  logic [7:0]   a0, a1, a2, a3;

  // Byte n of the block sits at bits [127-8n -: 8]; column c holds bytes 4c..4c+3.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    sb = '0;
    sr = '0;
    mc = '0;
    a0 = '0;
    a1 = '0;
    a2 = '0;
    a3 = '0;
    for (int i = 0; i < 16; i++) sb[127-8*i -: 8] = sbox(state[127-8*i -: 8]);
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      a0 = sr[127-32*c -: 8];
      a1 = sr[119-32*c -: 8];
      a2 = sr[111-32*c -: 8];
      a3 = sr[103-32*c -: 8];
      mc[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      mc[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      mc[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      mc[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    result = (mix_en ? mc : sr) ^ round_key;
  end

endmodule

// File: rtl/aes_core_ctrl.sv
// AES-128 encryption sequencer: load, key-expansion handshake, round stepping, result hold.
module aes_core_ctrl
  import aes_pkg::*;
#(
  parameter int NR         = NR_AES128,
  parameter int KX_TIMEOUT = 63
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [127:0] key,
  input  logic [127:0] plaintext,
  output logic [127:0] kx_init_key,
  output logic         kx_start,
  input  logic         kx_done,
  input  logic [127:0] round_key,
  output logic [3:0]   round_number,
  output logic [127:0] cyphertext,
  output logic         done,
  output logic         busy,
  output logic         kx_err
);

  localparam int CW = $clog2(KX_TIMEOUT + 1);

  ctrl_state_t   state;
  logic [127:0]  key_reg;
  logic [127:0]  pt_reg;
  logic [127:0]  state_reg;
  logic [127:0]  round_out;
  logic [CW-1:0] kx_cnt;
  logic          mix_en;

  assign kx_init_key = key_reg;
  assign mix_en      = (state != FINAL);

  aes_round_fn u_round_fn (
    .state     (state_reg),
    .round_key (round_key),
    .mix_en    (mix_en),
    .result    (round_out)
  );

  // NOTE: all registered state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      key_reg      <= '0;
      pt_reg       <= '0;
      state_reg    <= '0;
      cyphertext   <= '0;
      round_number <= '0;
      kx_cnt       <= '0;
      kx_start     <= 1'b0;
      done         <= 1'b0;
      busy         <= 1'b0;
      kx_err       <= 1'b0;
    end else begin
      kx_start <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (load) begin
            key_reg      <= key;
            pt_reg       <= plaintext;
            kx_err       <= 1'b0;
            done         <= 1'b0;
            busy         <= 1'b1;
            round_number <= '0;
            kx_start     <= 1'b1;
            state        <= KX_START;
          end
        end
        KX_START: begin
          kx_cnt <= '0;
          state  <= KX_WAIT;
        end
        KX_WAIT: begin
          if (kx_done) begin
            state <= ROUND0;
          end else begin
            kx_cnt <= kx_cnt + CW'(1);
            // This cycle is the KX_TIMEOUT-th one spent waiting.
            if (kx_cnt == CW'(KX_TIMEOUT - 1)) begin
              kx_err     <= 1'b1;
              cyphertext <= '0;
              state      <= ERR;
            end
          end
        end
        ROUND0: begin
          state_reg    <= pt_reg ^ round_key;
          round_number <= 4'd1;
          state        <= ROUNDS;
        end
        ROUNDS: begin
          state_reg    <= round_out;
          round_number <= round_number + 4'd1;
          if (round_number == 4'(NR - 1)) state <= FINAL;
        end
        FINAL: begin
          cyphertext <= round_out;
          done       <= 1'b1;
          busy       <= 1'b0;
          state      <= DONE;
        end
        ERR: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_core_ctrl.sv
// Directed bench for aes_core_ctrl with a behavioural key-expansion responder and FIPS-197 vectors.
module tb_aes_core_ctrl;

  typedef logic [10:0][127:0] rk_t;

  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam int KX_DELAY = 3;

  logic         clk;
  logic         reset;
  logic         load;
  logic [127:0] key;
  logic [127:0] plaintext;
  logic [127:0] kx_init_key;
  logic         kx_start;
  logic         kx_done;
  logic [127:0] round_key;
  logic [3:0]   round_number;
  logic [127:0] cyphertext;
  logic         done;
  logic         busy;
  logic         kx_err;

  logic kx_done_model;
  logic kx_done_spur;
  logic kx_enable;
  rk_t  rk_tab = '0;
  int   kx_wait = -1;
  int   kx_done_cyc = -1;
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;

  aes_core_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .load         (load),
    .key          (key),
    .plaintext    (plaintext),
    .kx_init_key  (kx_init_key),
    .kx_start     (kx_start),
    .kx_done      (kx_done),
    .round_key    (round_key),
    .round_number (round_number),
    .cyphertext   (cyphertext),
    .done         (done),
    .busy         (busy),
    .kx_err       (kx_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign kx_done   = kx_done_model | kx_done_spur;
  assign round_key = (round_number <= 4'd10) ? rk_tab[round_number] : '0;

  function automatic logic [7:0] tb_xtime(input logic [7:0] b);
    return b[7] ? ({b[6:0], 1'b0} ^ 8'h1b) : {b[6:0], 1'b0};
  endfunction

  function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = tb_xtime(x);
    end
    return p;
  endfunction

  // Inverse found by exhaustive search, then the standard affine map.
  function automatic logic [7:0] tb_sbox(input logic [7:0] x);
    logic [7:0] y = '0;
    logic [7:0] s;
    if (x != 8'h00)
      for (int k = 1; k < 256; k++) if (tb_gmul(x, 8'(k)) == 8'h01) y = 8'(k);
    s = 8'h63;
    for (int i = 0; i < 8; i++)
      s[i] = s[i] ^ y[i] ^ y[(i+4)%8] ^ y[(i+5)%8] ^ y[(i+6)%8] ^ y[(i+7)%8];
    return s;
  endfunction

  function automatic rk_t expand_key(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rcon = 8'h01;
    rk_t         r;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {tb_sbox(t[31:24]), tb_sbox(t[23:16]), tb_sbox(t[15:8]), tb_sbox(t[7:0])} ^ {rcon, 24'h0};
        rcon = tb_xtime(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int j = 0; j < 11; j++) r[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    return r;
  endfunction

  // Key-expansion responder: on kx_start, load the schedule and pulse kx_done KX_DELAY+1 cycles later.
  initial begin
    kx_done_model = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      kx_done_model = 1'b0;
      if (kx_wait == 0) begin
        kx_done_model = 1'b1;
        kx_done_cyc   = cyc;
      end
      if (kx_wait >= 0) kx_wait--;
      if (kx_start && kx_enable) begin
        rk_tab  = expand_key(kx_init_key);
        kx_wait = KX_DELAY;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [127:0] k, input logic [127:0] p);
    key       = k;
    plaintext = p;
    load      = 1'b1;
    tick();
    load = 1'b0;
    total++;
    if (kx_start !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || kx_err !== 1'b0 || kx_init_key !== k)
      $display("FAIL accept: kx_start=%b busy=%b done=%b kx_err=%b init_key=%h, need 1 1 0 0 %h",
               kx_start, busy, done, kx_err, kx_init_key, k);
    else passed++;
  endtask

  task automatic finish_vector(input string name, input logic [127:0] exp, input bit walk, input int t0);
    int got = -1;
    for (int i = 0; i < 200; i++) begin
      if (walk && kx_done_cyc > t0 && cyc > kx_done_cyc && cyc <= kx_done_cyc + 11) begin
        total++;
        if (round_number !== 4'(cyc - kx_done_cyc - 1))
          $display("FAIL %s walk: round_number=%0d need %0d", name, round_number, cyc - kx_done_cyc - 1);
        else passed++;
      end
      if (done === 1'b1) begin
        got = cyc;
        break;
      end
      tick();
    end
    total++;
    if (got < 0) $display("FAIL %s done_timeout: done never rose, need done within 200 cycles", name);
    else passed++;
    total++;
    if (got - kx_done_cyc != 12 || kx_done_cyc <= t0)
      $display("FAIL %s latency: done after %0d cycles, need 12", name, got - kx_done_cyc);
    else passed++;
    total++;
    if (cyphertext !== exp || busy !== 1'b0 || round_number !== 4'd10)
      $display("FAIL %s result: ct=%h busy=%b rn=%0d, need ct=%h busy=0 rn=10",
               name, cyphertext, busy, round_number, exp);
    else passed++;
  endtask

  task automatic run_vector(input string name, input logic [127:0] k, input logic [127:0] p,
                            input logic [127:0] exp, input bit walk);
    int t0 = cyc;
    start_load(k, p);
    finish_vector(name, exp, walk, t0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || kx_err !== 1'b0 || kx_start !== 1'b0 ||
        cyphertext !== '0 || round_number !== 4'd0 || kx_init_key !== '0)
      $display("FAIL reset_state: done=%b busy=%b kx_err=%b kx_start=%b ct=%h rn=%0d, need all zero",
               done, busy, kx_err, kx_start, cyphertext, round_number);
    else passed++;
  endtask

  task automatic test_fips_c1();
    run_vector("fips_c1", KEY_C1, PT_C1, CT_C1, 1'b0);
  endtask

  task automatic test_fips_b();
    run_vector("fips_b", KEY_B, PT_B, CT_B, 1'b1);
  endtask

  task automatic test_back_to_back();
    int t0;
    int seen = 0;
    run_vector("b2b_first", KEY_C1, PT_C1, CT_C1, 1'b0);
    t0 = cyc;
    start_load(KEY_B, PT_B);
    total++;
    if (cyphertext !== CT_C1) $display("FAIL b2b_hold: ct=%h need %h until FINAL", cyphertext, CT_C1);
    else passed++;
    for (int i = 0; i < 50 && seen == 0; i++) begin
      tick();
      if (round_number === 4'd3 && busy === 1'b1) seen = 1;
    end
    key       = KEY_C1;
    plaintext = '0;
    load      = 1'b1;
    tick();
    load = 1'b0;
    total++;
    if (seen == 0 || busy !== 1'b1 || kx_start !== 1'b0 || kx_init_key !== KEY_B || round_number !== 4'd4)
      $display("FAIL b2b_ignore: seen=%0d busy=%b kx_start=%b init_key=%h rn=%0d, need 1 1 0 %h 4",
               seen, busy, kx_start, kx_init_key, round_number, KEY_B);
    else passed++;
    finish_vector("b2b_second", CT_B, 1'b0, t0);
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    start_load(KEY_C1, PT_C1);
    for (int i = 0; i < 50 && seen == 0; i++) begin
      tick();
      if (round_number === 4'd5) seen = 1;
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    total++;
    if (seen == 0 || busy !== 1'b0 || done !== 1'b0 || cyphertext !== '0 || round_number !== 4'd0)
      $display("FAIL reset_mid: seen=%0d busy=%b done=%b ct=%h rn=%0d, need 1 0 0 0 0",
               seen, busy, done, cyphertext, round_number);
    else passed++;
    tick();
    run_vector("after_reset", KEY_C1, PT_C1, CT_C1, 1'b0);
  endtask

  task automatic test_kx_timeout();
    int s;
    int got = -1;
    kx_enable = 1'b0;
    start_load(KEY_B, PT_B);
    s = cyc;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (kx_err === 1'b1) begin
        got = cyc;
        break;
      end
    end
    total++;
    if (got - s != 64) $display("FAIL kx_timeout_time: kx_err after %0d cycles from KX_START, need 64", got - s);
    else passed++;
    tick();
    total++;
    if (kx_err !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || cyphertext !== '0 || kx_start !== 1'b0)
      $display("FAIL kx_timeout_idle: kx_err=%b busy=%b done=%b ct=%h kx_start=%b, need 1 0 0 0 0",
               kx_err, busy, done, cyphertext, kx_start);
    else passed++;
    kx_enable = 1'b1;
    run_vector("after_timeout", KEY_C1, PT_C1, CT_C1, 1'b0);
  endtask

  task automatic test_spurious_kx_done();
    int t0;
    kx_done_spur = 1'b1;
    tick();
    kx_done_spur = 1'b0;
    tick();
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || kx_start !== 1'b0 || cyphertext !== CT_C1)
      $display("FAIL spur_done: done=%b busy=%b kx_start=%b ct=%h, need 1 0 0 %h",
               done, busy, kx_start, cyphertext, CT_C1);
    else passed++;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    kx_done_spur = 1'b1;
    tick();
    kx_done_spur = 1'b0;
    tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || kx_start !== 1'b0 || round_number !== 4'd0)
      $display("FAIL spur_idle: done=%b busy=%b kx_start=%b rn=%0d, need 0 0 0 0",
               done, busy, kx_start, round_number);
    else passed++;
    // load and kx_done together in IDLE: only the load acts.
    t0 = cyc;
    kx_done_spur = 1'b1;
    start_load(KEY_B, PT_B);
    kx_done_spur = 1'b0;
    finish_vector("load_with_kx_done", CT_B, 1'b0, t0);
  endtask

  initial begin
    reset        = 1'b0;
    load         = 1'b0;
    key          = '0;
    plaintext    = '0;
    kx_done_spur = 1'b0;
    kx_enable    = 1'b1;
    test_reset();
    test_fips_c1();
    test_fips_b();
    test_back_to_back();
    test_reset_mid();
    test_kx_timeout();
    test_spurious_kx_done();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
